// File: rtl/cnn_axi_rd_master.sv
// cnn_axi_rd_master
// AXI3-style read initiator. Fetches a contiguous block of words from
// system memory in INCR bursts of at most MAX_BURST beats, never letting a
// burst cross a 4 KB boundary, with one burst outstanding at a time. Read
// data is passed straight through to a local valid/ready consumer stream.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   i_start             command pulse, accepted only when idle
//   i_base_addr         byte address of the first word (low bits ignored)
//   i_len_words         number of words to fetch (0 completes at once)
//   o_busy / o_done     command in progress / one-cycle completion pulse
//   o_err               sticky protocol/response error, cleared on start
//   o_data/o_valid/i_ready   consumer stream (combinational from R channel)
//   ar*                 AXI read address channel (initiator side)
//   r*                  AXI read data channel (initiator side)
module cnn_axi_rd_master #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int ID_MAX_WIDTH = 12,
  parameter int AXI_ID       = 0,
  parameter int LEN_WIDTH    = 16,
  parameter int MAX_BURST    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_start,
  input  logic [ADDR_WIDTH-1:0]   i_base_addr,
  input  logic [LEN_WIDTH-1:0]    i_len_words,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_err,
  output logic [DATA_WIDTH-1:0]   o_data,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [ID_MAX_WIDTH-1:0] arid,
  output logic [ADDR_WIDTH-1:0]   araddr,
  output logic [3:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arbrust,
  output logic [1:0]              arlock,
  output logic [3:0]              arcache,
  output logic [2:0]              arprot,
  output logic [3:0]              arqos,
  output logic [3:0]              arregion,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [ID_MAX_WIDTH-1:0] rid,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  input  logic                    rvalid,
  output logic                    rready
);

  localparam int BPB   = DATA_WIDTH / 8;
  localparam int ABITS = $clog2(BPB);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BPB - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;      // start of the next burst
  logic [LEN_WIDTH-1:0]    rem_q, rem_d;        // words not yet requested
  logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
  logic [3:0]              arlen_q, arlen_d;
  logic                    arvalid_q, arvalid_d;
  logic [3:0]              cnt_q, cnt_d;        // beat index inside burst
  logic                    err_q, err_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic [4:0]              cap_rb_s;
  logic [12:0]             to4k_s;
  logic [4:0]              beats_s;
  logic                    in_data_s;
  logic                    beat_s;
  logic                    last_s;
  logic                    err_beat_s;

  // Burst sizing: min(remaining, MAX_BURST, words left before the 4 KB page end)
  always_comb begin
    if (rem_q < LEN_WIDTH'(MAX_BURST)) begin
      cap_rb_s = 5'(rem_q);
    end else begin
      cap_rb_s = 5'(MAX_BURST);
    end
    to4k_s = (13'd4096 - {1'b0, addr_q[11:0]}) >> ABITS;
    if (13'(cap_rb_s) <= to4k_s) begin
      beats_s = cap_rb_s;
    end else begin
      beats_s = 5'(to4k_s);
    end
  end

  assign in_data_s  = (state_q == S_DATA);
  assign beat_s     = in_data_s & rvalid & i_ready;
  assign last_s     = (cnt_q == arlen_q);
  // rlast must coincide exactly with the counted final beat
  assign err_beat_s = (rresp != 2'b00) || (rid != ID_MAX_WIDTH'(AXI_ID)) || (rlast != last_s);

  // Next-state and datapath update logic
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    arvalid_d = arvalid_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          err_d  = 1'b0;
          addr_d = i_base_addr & ALIGN_MASK;
          rem_d  = i_len_words;
          if (i_len_words != {LEN_WIDTH{1'b0}}) begin
            state_d = S_ADDR;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ADDR: begin
        // First ADDR cycle sizes the burst; arvalid rises from the next cycle.
        if (!arvalid_q) begin
          araddr_d  = addr_q;
          arlen_d   = 4'(beats_s - 5'd1);
          arvalid_d = 1'b1;
          addr_d    = addr_q + (ADDR_WIDTH'(beats_s) << ABITS);
          rem_d     = rem_q - LEN_WIDTH'(beats_s);
        end else if (arready) begin
          arvalid_d = 1'b0;
          cnt_d     = 4'd0;
          state_d   = S_DATA;
        end else begin
          arvalid_d = 1'b1;
        end
      end
      S_DATA: begin
        if (beat_s) begin
          err_d = err_q | err_beat_s;
          if (last_s) begin
            cnt_d = 4'd0;
            if (rem_q != {LEN_WIDTH{1'b0}}) begin
              state_d = S_ADDR;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d   = S_IDLE;
        arvalid_d = 1'b0;
      end
    endcase
    busy_d = (state_d == S_ADDR) || (state_d == S_DATA);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= {ADDR_WIDTH{1'b0}};
      rem_q     <= {LEN_WIDTH{1'b0}};
      araddr_q  <= {ADDR_WIDTH{1'b0}};
      arlen_q   <= 4'd0;
      arvalid_q <= 1'b0;
      cnt_q     <= 4'd0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      arvalid_q <= arvalid_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign o_busy   = busy_q;
  assign o_done   = done_q;
  assign o_err    = err_q;
  assign o_valid  = in_data_s & rvalid;
  assign o_data   = in_data_s ? rdata : {DATA_WIDTH{1'b0}};
  assign rready   = in_data_s & i_ready;

  assign arid     = ID_MAX_WIDTH'(AXI_ID);
  assign araddr   = araddr_q;
  assign arlen    = arlen_q;
  assign arsize   = 3'(ABITS);
  assign arbrust  = 2'b01;
  assign arlock   = 2'b00;
  assign arcache  = 4'b0000;
  assign arprot   = 3'b000;
  assign arqos    = 4'b0000;
  assign arregion = 4'b0000;
  assign arvalid  = arvalid_q;

endmodule
